lcv_mul_acc_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshaking on both sides, a persistent internal accumulator and optional saturation. It is the next generation of the fixed-width single-cycle multiply-add blocks. It sits between operand-fetch logic and a result consumer in DSP datapaths. The block maps onto one DSP slice plus a fabric output stage.

---
 rtl/lcv_mul_acc_pkg.sv | 13 +
 rtl/lcv_sat_add.sv | 31 +++
 rtl/lcv_mul_acc_pipe.sv | 128 ++++++++++++
 tb/tb_lcv_mul_acc_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and constants for the pipelined multiply-accumulate family.
package lcv_mul_acc_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MAC  = 2'd1,
    OP_MSUB = 2'd2,
    OP_LOAD = 2'd3
  } lcv_mul_acc_op_t;

  localparam int LCV_MUL_ACC_LAT = 3;

endpackage

// File: rtl/lcv_sat_add.sv
// Signed add/subtract formed one bit wider than the operands, with overflow
// detection and optional clamping to the representable range.
module lcv_sat_add #(
  parameter int WIDTH    = 40,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] wide;

  always_comb begin
    if (sub) begin
      wide = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    end else begin
      wide = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    end
    // Overflow when the guard bit disagrees with the result sign bit.
    ovf = wide[WIDTH] ^ wide[WIDTH-1];
    if (ovf && (SATURATE != 0)) begin
      sum = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage signed multiply-accumulate with valid/ready on both sides and a
// global stall; the accumulator lives in the last stage so MACs chain freely.
(* use_dsp48 = "yes" *)
module lcv_mul_acc_pipe
  import lcv_mul_acc_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic [ACC_WIDTH-1:0] in_c,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [ACC_WIDTH-1:0] acc_value
);

  if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_width_check
    $error("lcv_mul_acc_pipe: ACC_WIDTH must be at least A_WIDTH + B_WIDTH");
  end

  logic stall;

  logic                        s1_valid;
  logic signed [A_WIDTH-1:0]   s1_a;
  logic signed [B_WIDTH-1:0]   s1_b;
  logic [ACC_WIDTH-1:0]        s1_c;
  lcv_mul_acc_op_t             s1_op;

  logic                        s2_valid;
  logic signed [ACC_WIDTH-1:0] s2_p;
  logic [ACC_WIDTH-1:0]        s2_c;
  lcv_mul_acc_op_t             s2_op;

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH-1:0]        add_x;
  logic [ACC_WIDTH-1:0]        add_y;
  logic                        add_sub;
  logic [ACC_WIDTH-1:0]        res;
  logic                        res_ovf;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign acc_value = acc;
  assign prod      = s1_a * s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  // Operand and product registers carry no reset so they pack into the DSP.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_a  <= in_a;
      s1_b  <= in_b;
      s1_c  <= in_c;
      s1_op <= lcv_mul_acc_op_t'(in_op);
      s2_p  <= ACC_WIDTH'(prod);
      s2_c  <= s1_c;
      s2_op <= s1_op;
    end
  end

  always_comb begin
    add_x   = s2_p;
    add_y   = s2_c;
    add_sub = 1'b0;
    case (s2_op)
      OP_MAC: begin
        add_x = acc;
        add_y = s2_p;
      end
      OP_MSUB: begin
        add_x   = acc;
        add_y   = s2_p;
        add_sub = 1'b1;
      end
      default: begin
      end
    endcase
  end

  lcv_sat_add #(
    .WIDTH    (ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .sum (res),
    .ovf (res_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= res;
        out_ovf  <= res_ovf;
        if (s2_op != OP_MUL) begin
          acc <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Directed and randomised checks of the multiply-accumulate pipeline.
module tb_lcv_mul_acc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [39:0] in_c;
  logic [31:0] c32;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_data, acc_value;
  logic        s32_in_ready, s32_out_valid, s32_out_ovf;
  logic [31:0] s32_out_data, s32_acc;
  logic        w32_in_ready, w32_out_valid, w32_out_ovf;
  logic [31:0] w32_out_data, w32_acc;

  int n_checks = 0;
  int n_fail   = 0;

  assign c32 = in_c[31:0];

  always #5 clk = ~clk;

  lcv_mul_acc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .acc_value(acc_value)
  );

  lcv_mul_acc_pipe #(.ACC_WIDTH(32), .SATURATE(1)) dut_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s32_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(c32), .in_op(in_op),
    .out_valid(s32_out_valid), .out_ready(out_ready), .out_data(s32_out_data),
    .out_ovf(s32_out_ovf), .acc_value(s32_acc)
  );

  lcv_mul_acc_pipe #(.ACC_WIDTH(32), .SATURATE(0)) dut_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w32_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(c32), .in_op(in_op),
    .out_valid(w32_out_valid), .out_ready(out_ready), .out_data(w32_out_data),
    .out_ovf(w32_out_ovf), .acc_value(w32_acc)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] op, input int a, input int b, input logic [39:0] c);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_c     = c;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  // Reference behaviour of the default (40-bit, saturating) configuration.
  task automatic model(input logic [1:0] op, input logic signed [15:0] a,
                       input logic signed [15:0] b, input logic [39:0] c,
                       inout longint acc, output logic [39:0] res, output logic ovf);
    longint p, cs, sum;
    longint max_v, min_v;
    max_v = (64'sd1 <<< 39) - 1;
    min_v = -(64'sd1 <<< 39);
    p  = longint'(a) * longint'(b);
    cs = longint'($signed(c));
    case (op)
      2'd1:    sum = acc + p;
      2'd2:    sum = acc - p;
      default: sum = p + cs;
    endcase
    ovf = 1'b0;
    if (sum > max_v) begin
      ovf = 1'b1;
      res = 40'h7F_FFFF_FFFF;
    end else if (sum < min_v) begin
      ovf = 1'b1;
      res = 40'h80_0000_0000;
    end else begin
      res = sum[39:0];
    end
    if (op != 2'd0) acc = longint'($signed(res));
  endtask

  initial begin
    logic [40:0] exp_q[$];
    logic [40:0] e;
    logic [39:0] m_res;
    logic        m_ovf;
    longint      m_acc;
    int          sent, rcvd, cycles;
    bit          acc_now, con_now;
    int          sel;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_op = '0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 40'(out_valid), 40'd0);
    chk("rst_out_data", out_data, 40'd0);
    chk("rst_out_ovf", 40'(out_ovf), 40'd0);
    chk("rst_acc", acc_value, 40'd0);
    chk("rst_in_ready", 40'(in_ready), 40'd1);
    @(negedge clk);
    rst = 1'b0;

    // LOAD/MAC/MSUB back-to-back: 22, 32, 31 on consecutive cycles.
    beat(2'd3, 3, 4, 40'd10);
    beat(2'd1, 2, 5, 40'd0);
    beat(2'd2, 1, 1, 40'd0);
    chk("seq_v0", 40'(out_valid), 40'd1);
    chk("seq_load", out_data, 40'd22);
    idle();
    chk("seq_mac", out_data, 40'd32);
    idle();
    chk("seq_msub", out_data, 40'd31);
    chk("seq_acc", acc_value, 40'd31);
    idle();
    chk("seq_drained", 40'(out_valid), 40'd0);

    // MUL leaves the accumulator alone.
    beat(2'd3, 0, 0, 40'd100);
    beat(2'd0, -7, 6, 40'd2);
    idle();
    chk("mul_load", out_data, 40'd100);
    idle();
    chk("mul_data", out_data, 40'(-40));
    chk("mul_ovf", 40'(out_ovf), 40'd0);
    chk("mul_acc", acc_value, 40'd100);

    // 32-bit saturate vs wrap, positive then negative overflow.
    beat(2'd3, 0, 0, 40'h7FFF_FFF0);
    beat(2'd1, 16, 16, 40'd0);
    beat(2'd3, 0, 0, 40'h8000_0010);
    chk("s32_load", 40'(s32_out_data), 40'h7FFF_FFF0);
    beat(2'd2, 16, 16, 40'd0);
    chk("s32_pos_data", 40'(s32_out_data), 40'h7FFF_FFFF);
    chk("s32_pos_ovf", 40'(s32_out_ovf), 40'd1);
    chk("s32_pos_acc", 40'(s32_acc), 40'h7FFF_FFFF);
    chk("w32_pos_data", 40'(w32_out_data), 40'h8000_00F0);
    chk("w32_pos_ovf", 40'(w32_out_ovf), 40'd1);
    idle();
    chk("s32_load2_ovf", 40'(s32_out_ovf), 40'd0);
    idle();
    chk("s32_neg_data", 40'(s32_out_data), 40'h8000_0000);
    chk("s32_neg_ovf", 40'(s32_out_ovf), 40'd1);
    chk("w32_neg_data", 40'(w32_out_data), 40'h7FFF_FF10);
    chk("w32_neg_acc", 40'(w32_acc), 40'h7FFF_FF10);

    // Stall: three MACs in flight with the consumer blocked for five edges.
    beat(2'd3, 0, 0, 40'd0);
    idle(); idle(); idle();
    out_ready = 1'b0;
    beat(2'd1, 1, 1, 40'd0);
    beat(2'd1, 1, 1, 40'd0);
    beat(2'd1, 1, 1, 40'd0);
    chk("stall_v", 40'(out_valid), 40'd1);
    chk("stall_first", out_data, 40'd1);
    chk("stall_in_ready", 40'(in_ready), 40'd0);
    beat(2'd1, 100, 100, 40'd0);
    beat(2'd1, 100, 100, 40'd0);
    chk("stall_hold", out_data, 40'd1);
    chk("stall_acc", acc_value, 40'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_second", out_data, 40'd2);
    chk("stall_acc2", acc_value, 40'd2);
    tick();
    chk("stall_third", out_data, 40'd3);
    tick();
    chk("stall_no_dup", 40'(out_valid), 40'd0);
    chk("stall_acc3", acc_value, 40'd3);

    // Reset with two beats in flight, then a beat on the first free edge.
    beat(2'd3, 0, 0, 40'd5);
    beat(2'd1, 1, 1, 40'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 40'(out_valid), 40'd0);
    chk("mid_rst_data", out_data, 40'd0);
    chk("mid_rst_acc", acc_value, 40'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(2'd3, 2, 2, 40'd1);
    chk("post_rst_e1", 40'(out_valid), 40'd0);
    idle();
    chk("post_rst_e2", 40'(out_valid), 40'd0);
    idle();
    chk("post_rst_first", out_data, 40'd5);
    chk("post_rst_first_v", 40'(out_valid), 40'd1);
    idle();
    chk("post_rst_clean", 40'(out_valid), 40'd0);

    // Random valid/ready traffic against the reference model.
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; sent = 0; rcvd = 0; cycles = 0;
    while (rcvd < 1000 && cycles < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op = 2'($urandom_range(0, 3));
      in_a  = 16'($urandom);
      in_b  = 16'($urandom);
      sel   = int'($urandom_range(0, 3));
      if (sel == 0)      in_c = 40'h7F_FFFF_FFFF - 40'($urandom_range(0, 1 << 20));
      else if (sel == 1) in_c = 40'h80_0000_0000 + 40'($urandom_range(0, 1 << 20));
      else               in_c = {8'($urandom), 32'($urandom)};
      #1;
      acc_now = in_valid && in_ready;
      con_now = out_valid && out_ready;
      if (con_now) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 40'(out_valid), 40'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_data", out_data, e[39:0]);
          chk("rand_ovf", 40'(out_ovf), 40'(e[40]));
        end
        rcvd++;
      end
      if (acc_now) begin
        model(in_op, in_a, in_b, in_c, m_acc, m_res, m_ovf);
        exp_q.push_back({m_ovf, m_res});
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("rand_all_received", 40'(rcvd), 40'd1000);
    chk("rand_final_acc", acc_value, m_acc[39:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
